// File: rtl/if_fetch.sv
// Instruction fetch stage: sequential fetch with branch redirect, squash of in-flight reads, 1 inst/cycle at single-cycle ack.
// IF/ID outputs register one cycle after ack; stall_i freezes outputs and parks an acked word in a one-entry buffer.
module if_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [15:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [15:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [15:0] imem_data_i,
   output logic [15:0] pc_o,
   output logic [15:0] inst_o,
   output logic        inst_valid_o
);

   typedef enum logic {S_REQ, S_HOLD} state_t;

   state_t      r_state, w_state;
   logic [15:0] r_fetch_pc, w_fetch_pc;
   logic [15:0] r_tgt, w_tgt;
   logic [15:0] r_buf, w_buf;
   logic        r_squash, w_squash;
   logic [15:0] r_pc, w_pc;
   logic [15:0] r_inst, w_inst;
   logic        r_valid, w_valid;
   logic        w_take_br;
   logic [15:0] w_pc_inc;

   assign w_take_br = branch_flag_i & ~stall_i;
   assign w_pc_inc  = r_fetch_pc + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_fetch_pc <= RESET_PC;
         r_tgt      <= RESET_PC;
         r_buf      <= '0;
         r_squash   <= 1'b0;
         r_pc       <= RESET_PC;
         r_inst     <= NOP_INST;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_fetch_pc <= w_fetch_pc;
         r_tgt      <= w_tgt;
         r_buf      <= w_buf;
         r_squash   <= w_squash;
         r_pc       <= w_pc;
         r_inst     <= w_inst;
         r_valid    <= w_valid;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_fetch_pc = r_fetch_pc;
      w_tgt      = r_tgt;
      w_buf      = r_buf;
      w_squash   = r_squash;
      w_pc       = r_pc;
      w_inst     = r_inst;
      w_valid    = r_valid;
      // An unstalled cycle is a bubble unless a word gets delivered below.
      if (!stall_i) begin
         w_inst  = NOP_INST;
         w_valid = 1'b0;
      end
      case (r_state)
         S_REQ: begin
            if (imem_ack_i) begin
               if (r_squash) begin
                  w_squash   = 1'b0;
                  w_fetch_pc = w_take_br ? branch_addr_i : r_tgt;
               end else if (w_take_br) begin
                  w_fetch_pc = branch_addr_i;
               end else if (stall_i) begin
                  w_buf   = imem_data_i;
                  w_state = S_HOLD;
               end else begin
                  w_inst     = imem_data_i;
                  w_pc       = w_pc_inc;
                  w_valid    = 1'b1;
                  w_fetch_pc = w_pc_inc;
               end
            end else if (w_take_br) begin
               // Address must stay stable until the memory acks, so the target waits in r_tgt.
               w_squash = 1'b1;
               w_tgt    = branch_addr_i;
            end
         end
         S_HOLD: begin
            if (!stall_i) begin
               w_state = S_REQ;
               if (branch_flag_i) begin
                  w_fetch_pc = branch_addr_i;
                  w_buf      = '0;
               end else begin
                  w_inst     = r_buf;
                  w_pc       = w_pc_inc;
                  w_valid    = 1'b1;
                  w_fetch_pc = w_pc_inc;
               end
            end
         end
         default: w_state = S_REQ;
      endcase
   end

   assign imem_req_o   = (r_state == S_REQ) & ~rst;
   assign imem_addr_o  = r_fetch_pc;
   assign pc_o         = r_pc;
   assign inst_o       = r_inst;
   assign inst_valid_o = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: memory word at address a is 0x4A0F + a; ack gated by ack_en.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [15:0] branch_addr_i;
   logic        imem_req_o;
   logic [15:0] imem_addr_o;
   logic        imem_ack_i;
   logic [15:0] imem_data_i;
   logic [15:0] pc_o;
   logic [15:0] inst_o;
   logic        inst_valid_o;

   logic ack_en;
   logic ack_force;
   int   checks;
   int   failures;

   if_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .branch_flag_i(branch_flag_i),
      .branch_addr_i(branch_addr_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_ack_i   (imem_ack_i),
      .imem_data_i  (imem_data_i),
      .pc_o         (pc_o),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o)
   );

   always #5 clk = ~clk;

   assign imem_ack_i  = ack_en & (imem_req_o | ack_force);
   assign imem_data_i = 16'h4A0F + imem_addr_o;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = 16'h0;
      ack_en = 1'b1; ack_force = 1'b0;
      step(); step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0000, 16'h0800, 1'b0}) begin
         failures++;
         $display("FAIL reset_out got pc=%h inst=%h v=%b exp pc=0000 inst=0800 v=0", pc_o, inst_o, inst_valid_o);
      end
      checks++;
      if (imem_req_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_req got=%b exp=0", imem_req_o);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 16'h0000}) begin
         failures++;
         $display("FAIL reset_first_req got req=%b addr=%h exp req=1 addr=0000", imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_back_to_back();
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0001, 16'h4A0F, 1'b1}) begin
         failures++;
         $display("FAIL b2b_0 got pc=%h inst=%h v=%b exp pc=0001 inst=4a0f v=1", pc_o, inst_o, inst_valid_o);
      end
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0002, 16'h4A10, 1'b1}) begin
         failures++;
         $display("FAIL b2b_1 got pc=%h inst=%h v=%b exp pc=0002 inst=4a10 v=1", pc_o, inst_o, inst_valid_o);
      end
      step(); step(); step();
      checks++;
      if ({pc_o, inst_o, imem_addr_o} !== {16'h0005, 16'h4A13, 16'h0005}) begin
         failures++;
         $display("FAIL b2b_4 got pc=%h inst=%h addr=%h exp pc=0005 inst=4a13 addr=0005", pc_o, inst_o, imem_addr_o);
      end
   endtask

   task automatic test_stall_hold();
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({pc_o, inst_o, inst_valid_o, imem_req_o} !== {16'h0005, 16'h4A13, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL stall_frozen_%0d got pc=%h inst=%h v=%b req=%b exp pc=0005 inst=4a13 v=1 req=0",
                     i, pc_o, inst_o, inst_valid_o, imem_req_o);
         end
      end
      stall_i = 1'b0;
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o} !== {16'h0006, 16'h4A14, 1'b1, 1'b1, 16'h0006}) begin
         failures++;
         $display("FAIL stall_release got pc=%h inst=%h v=%b req=%b addr=%h exp pc=0006 inst=4a14 v=1 req=1 addr=0006",
                  pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o);
      end
   endtask

   task automatic test_branch_squash();
      step();
      ack_en = 1'b0;
      branch_flag_i = 1'b1; branch_addr_i = 16'h0040;
      for (int i = 0; i < 3; i++) begin
         step();
         branch_flag_i = 1'b0;
         checks++;
         if ({imem_req_o, imem_addr_o, inst_o, inst_valid_o} !== {1'b1, 16'h0007, 16'h0800, 1'b0}) begin
            failures++;
            $display("FAIL squash_hold_%0d got req=%b addr=%h inst=%h v=%b exp req=1 addr=0007 inst=0800 v=0",
                     i, imem_req_o, imem_addr_o, inst_o, inst_valid_o);
         end
      end
      ack_en = 1'b1;
      step();
      checks++;
      if ({imem_addr_o, pc_o, inst_o, inst_valid_o} !== {16'h0040, 16'h0007, 16'h0800, 1'b0}) begin
         failures++;
         $display("FAIL squash_drop got addr=%h pc=%h inst=%h v=%b exp addr=0040 pc=0007 inst=0800 v=0",
                  imem_addr_o, pc_o, inst_o, inst_valid_o);
      end
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0041, 16'h4A4F, 1'b1}) begin
         failures++;
         $display("FAIL squash_target got pc=%h inst=%h v=%b exp pc=0041 inst=4a4f v=1", pc_o, inst_o, inst_valid_o);
      end
   endtask

   task automatic test_branch_stalled();
      stall_i = 1'b1; branch_flag_i = 1'b1; branch_addr_i = 16'h0100; ack_en = 1'b0;
      step(); step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o, imem_addr_o} !== {16'h0041, 16'h4A4F, 1'b1, 16'h0041}) begin
         failures++;
         $display("FAIL br_stall_ignored got pc=%h inst=%h v=%b addr=%h exp pc=0041 inst=4a4f v=1 addr=0041",
                  pc_o, inst_o, inst_valid_o, imem_addr_o);
      end
      stall_i = 1'b0; branch_flag_i = 1'b0; ack_en = 1'b1;
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o, imem_addr_o} !== {16'h0042, 16'h4A50, 1'b1, 16'h0042}) begin
         failures++;
         $display("FAIL br_stall_seq got pc=%h inst=%h v=%b addr=%h exp pc=0042 inst=4a50 v=1 addr=0042",
                  pc_o, inst_o, inst_valid_o, imem_addr_o);
      end
   endtask

   task automatic test_branch_ack();
      branch_flag_i = 1'b1; branch_addr_i = 16'h0080;
      step();
      branch_flag_i = 1'b0;
      checks++;
      if ({imem_addr_o, pc_o, inst_o, inst_valid_o} !== {16'h0080, 16'h0042, 16'h0800, 1'b0}) begin
         failures++;
         $display("FAIL br_ack_drop got addr=%h pc=%h inst=%h v=%b exp addr=0080 pc=0042 inst=0800 v=0",
                  imem_addr_o, pc_o, inst_o, inst_valid_o);
      end
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0081, 16'h4A8F, 1'b1}) begin
         failures++;
         $display("FAIL br_ack_target got pc=%h inst=%h v=%b exp pc=0081 inst=4a8f v=1", pc_o, inst_o, inst_valid_o);
      end
   endtask

   task automatic test_branch_hold();
      stall_i = 1'b1;
      step();
      stall_i = 1'b0; branch_flag_i = 1'b1; branch_addr_i = 16'h0200;
      step();
      branch_flag_i = 1'b0;
      checks++;
      if ({imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o} !== {1'b1, 16'h0200, 16'h0081, 16'h0800, 1'b0}) begin
         failures++;
         $display("FAIL br_hold_drop got req=%b addr=%h pc=%h inst=%h v=%b exp req=1 addr=0200 pc=0081 inst=0800 v=0",
                  imem_req_o, imem_addr_o, pc_o, inst_o, inst_valid_o);
      end
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0201, 16'h4C0F, 1'b1}) begin
         failures++;
         $display("FAIL br_hold_target got pc=%h inst=%h v=%b exp pc=0201 inst=4c0f v=1", pc_o, inst_o, inst_valid_o);
      end
   endtask

   task automatic test_wrap();
      branch_flag_i = 1'b1; branch_addr_i = 16'hFFFF;
      step();
      branch_flag_i = 1'b0;
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o, imem_addr_o} !== {16'h0000, 16'h4A0E, 1'b1, 16'h0000}) begin
         failures++;
         $display("FAIL wrap got pc=%h inst=%h v=%b addr=%h exp pc=0000 inst=4a0e v=1 addr=0000",
                  pc_o, inst_o, inst_valid_o, imem_addr_o);
      end
   endtask

   task automatic test_reset_mid();
      branch_flag_i = 1'b1; branch_addr_i = 16'h0300;
      step();
      branch_flag_i = 1'b0; ack_en = 1'b0;
      step();
      checks++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 16'h0300}) begin
         failures++;
         $display("FAIL rstmid_pending got req=%b addr=%h exp req=1 addr=0300", imem_req_o, imem_addr_o);
      end
      rst = 1'b1; ack_en = 1'b1; ack_force = 1'b1;
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o, imem_req_o} !== {16'h0000, 16'h0800, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL rstmid_out got pc=%h inst=%h v=%b req=%b exp pc=0000 inst=0800 v=0 req=0",
                  pc_o, inst_o, inst_valid_o, imem_req_o);
      end
      rst = 1'b0; ack_en = 1'b0; ack_force = 1'b0;
      #1;
      checks++;
      if ({imem_req_o, imem_addr_o} !== {1'b1, 16'h0000}) begin
         failures++;
         $display("FAIL rstmid_restart got req=%b addr=%h exp req=1 addr=0000", imem_req_o, imem_addr_o);
      end
      step();
      ack_en = 1'b1;
      step();
      checks++;
      if ({pc_o, inst_o, inst_valid_o} !== {16'h0001, 16'h4A0F, 1'b1}) begin
         failures++;
         $display("FAIL rstmid_fetch got pc=%h inst=%h v=%b exp pc=0001 inst=4a0f v=1", pc_o, inst_o, inst_valid_o);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_back_to_back();
      test_stall_hold();
      test_branch_squash();
      test_branch_stalled();
      test_branch_ack();
      test_branch_hold();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 16'h0800, meaning the bubble instruction driven to decode.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high (RstEnable = 1).
REQ-005 SHALL have port stall_i, input, 1, meaning decode/ctrl stall: hold the IF/ID outputs.
REQ-006 SHALL have port branch_flag_i, input, 1, meaning decode has resolved a taken branch or jump this cycle.
REQ-007 SHALL have port branch_addr_i, input, 16, meaning the branch target address.
REQ-008 SHALL have port imem_req_o, output, 1, meaning instruction-memory read request.
REQ-009 SHALL have port imem_addr_o, output, 16, meaning the read address.
REQ-010 SHALL have port imem_ack_i, input, 1, meaning read data valid and request accepted.
REQ-011 SHALL have port imem_data_i, input, 16, meaning instruction word, valid when imem_ack_i=1.
REQ-012 SHALL have port pc_o, output, 16, meaning fetch address of inst_o plus 1, driven to decode pc_i.
REQ-013 SHALL have port inst_o, output, 16, meaning instruction to decode inst_i.
REQ-014 SHALL have port inst_valid_o, output, 1, meaning inst_o is a real fetched instruction (0 = bubble).

Function
REQ-015 SHALL keep an internal fetch_pc (16 bits), an instruction buffer, a squash flag and a state in {S_REQ, S_HOLD}.
REQ-016 In S_REQ, SHALL drive imem_req_o=1 and imem_addr_o=fetch_pc, holding both stable every cycle until the cycle with imem_ack_i=1.
REQ-017 On ack with squash=0 and stall_i=0: next cycle inst_o=imem_data_i, pc_o=fetch_pc+1, inst_valid_o=1; fetch_pc increments; remain in S_REQ (back-to-back fetch, throughput 1 instruction/cycle with single-cycle ack).
REQ-018 On ack with squash=0 and stall_i=1: SHALL store data in the buffer, go to S_HOLD (imem_req_o=0), leave IF/ID outputs unchanged.
REQ-019 In S_HOLD, on the first cycle with stall_i=0: SHALL deliver the buffer per REQ-017 and return to S_REQ.
REQ-020 Any cycle with stall_i=1 SHALL leave pc_o, inst_o, inst_valid_o unchanged.
REQ-021 Any cycle with stall_i=0 in which no instruction is delivered SHALL produce inst_o=NOP_INST, inst_valid_o=0 next cycle, with pc_o unchanged.
REQ-022 branch_flag_i SHALL be honoured only when stall_i=0; with stall_i=1 it is ignored.
REQ-023 Honoured branch: next cycle inst_o=NOP_INST, inst_valid_o=0; fetch_pc=branch_addr_i; no delay slot.
REQ-024 Branch in a cycle where ack arrives: that ack's data SHALL be discarded; next request uses branch_addr_i.
REQ-025 Branch while a request is outstanding without ack: SHALL set squash, keep req/addr stable until ack, discard that data, clear squash, then request branch_addr_i.
REQ-026 Branch in S_HOLD: SHALL discard the buffer and enter S_REQ at branch_addr_i.
REQ-027 fetch_pc and pc_o arithmetic SHALL be modulo 2^16 (16'hFFFF + 1 = 16'h0000).
REQ-028 imem_req_o SHALL never deassert between request and ack except via reset.

Reset
REQ-029 With rst=1 at a clock edge: fetch_pc=RESET_PC, pc_o=RESET_PC, inst_o=NOP_INST, inst_valid_o=0, imem_req_o=0, squash=0, buffer cleared, state=S_REQ.
REQ-030 Reset mid-request SHALL abandon the outstanding request; an ack arriving in the reset cycle is ignored.
REQ-031 First cycle after rst deasserts SHALL assert imem_req_o=1 with imem_addr_o=RESET_PC.

Verification
REQ-032 Reset, single-cycle ack, memory words 0x4A0F,0x4A10 at 0,1 -> inst_o 0x4A0F/pc_o 1, then 0x4A10/pc_o 2, inst_valid_o=1 each.
REQ-033 Ack at addr 5 with stall_i=1 for 3 cycles -> outputs frozen, imem_req_o=0; stall release -> inst_o=mem[5], pc_o=6, next req addr 6.
REQ-034 Branch_flag_i=1, branch_addr_i=0x0040 while addr 7 pending 3 cycles without ack -> addr 7 held until ack, data dropped, inst_valid_o=0, next req addr 0x0040.
REQ-035 Branch with stall_i=1 -> ignored, sequential fetch continues after stall.
REQ-036 fetch_pc=0xFFFF delivered -> pc_o=0x0000, next req addr 0x0000.
REQ-037 rst=1 mid-request with 2-cycle-latency memory -> all outputs per REQ-029; restart fetch at RESET_PC.
